// File: rtl/regfile_wb_scheduler_if.sv
// Writeback, register-file write port and issue-side signals of the scheduler.
// master: the pipeline side (writeback sources and issue stage).
// slave: the scheduler itself.
interface regfile_wb_scheduler_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
);
    logic              alu_valid;
    logic              alu_ready;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_value;
    logic              ld_valid;
    logic              ld_ready;
    logic [REG_AW-1:0] ld_rd;
    logic [XLEN-1:0]   ld_value;
    logic              reg_write_en;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rd_value;
    logic              issue_en;
    logic [REG_AW-1:0] issue_rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              stall;
    logic              idle;

    modport master (
        output alu_valid, alu_rd, alu_value,
        output ld_valid, ld_rd, ld_value,
        output issue_en, issue_rd, rs1, rs2,
        input  alu_ready, ld_ready,
        input  reg_write_en, rd, rd_value,
        input  stall, idle
    );

    modport slave (
        input  alu_valid, alu_rd, alu_value,
        input  ld_valid, ld_rd, ld_value,
        input  issue_en, issue_rd, rs1, rs2,
        output alu_ready, ld_ready,
        output reg_write_en, rd, rd_value,
        output stall, idle
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Register-file write port scheduler: round-robin arbitration between the ALU
// and load-unit writebacks, a registered write stage, and a pending-write
// scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_scheduler #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input logic                  clk,
    input logic                  rst,
    regfile_wb_scheduler_if.slave bus
);
    localparam int unsigned NumRegs = 2 ** REG_AW;

    logic              last_grant_ld;  // 0: ALU won last, so the first tie goes to the load unit
    logic              grant_alu;
    logic              grant_ld;
    logic              accept;
    logic [REG_AW-1:0] accept_rd;
    logic [XLEN-1:0]   accept_value;
    logic              issue_ok;

    logic [NumRegs-1:0] pending_q;
    logic [NumRegs-1:0] pending_d;
    logic               wr_en_q;
    logic [REG_AW-1:0]  rd_q;
    logic [XLEN-1:0]    rd_value_q;

    // Round-robin grant: on contention the source that did not win last time goes.
    always_comb begin
        grant_ld     = bus.ld_valid & (~bus.alu_valid | ~last_grant_ld);
        grant_alu    = bus.alu_valid & ~grant_ld;
        accept       = grant_ld | grant_alu;
        accept_rd    = grant_ld ? bus.ld_rd : bus.alu_rd;
        accept_value = grant_ld ? bus.ld_value : bus.alu_value;
    end

    assign bus.alu_ready = grant_alu;
    assign bus.ld_ready  = grant_ld;

    assign bus.stall = pending_q[bus.rs1] | pending_q[bus.rs2] |
                       (bus.issue_en & pending_q[bus.issue_rd]);
    assign issue_ok  = bus.issue_en & ~bus.stall & (bus.issue_rd != '0);

    // Scoreboard next state: clear on the outgoing write, then set on issue so set wins.
    always_comb begin
        pending_d = pending_q;
        if (wr_en_q) begin
            pending_d[rd_q] = 1'b0;
        end
        if (issue_ok) begin
            pending_d[bus.issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Arbitration history, registered write stage and scoreboard state.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_ld <= 1'b0;
            wr_en_q       <= 1'b0;
            rd_q          <= '0;
            rd_value_q    <= '0;
            pending_q     <= '0;
        end else begin
            pending_q <= pending_d;
            // An accepted write to x0 is consumed but never reaches the register file.
            wr_en_q   <= accept & (accept_rd != '0);
            if (accept) begin
                last_grant_ld <= grant_ld;
            end
            if (accept && (accept_rd != '0)) begin
                rd_q       <= accept_rd;
                rd_value_q <= accept_value;
            end
        end
    end

    assign bus.reg_write_en = wr_en_q;
    assign bus.rd           = rd_q;
    assign bus.rd_value     = rd_value_q;
    assign bus.idle         = (pending_q == '0) & ~wr_en_q;
endmodule
